// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_gen
//  Description : Free-running WIDTH-bit counter plus CHANNELS independent
//                programmable dividers. Each channel emits a registered
//                one-cycle tick strobe every (D+1) cycles and a square-wave
//                enable that toggles on every tick. Outputs are clock-enable
//                strobes; no clock is gated here.
//  Option      : define CLK_DIV_GEN_ONESHOT_EN to add per-channel one-shot
//                mode (oneshot_i / done_o ports).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
    parameter int               WIDTH       = 32,
    parameter int               CHANNELS    = 4,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [WIDTH-1:0]    free_cnt,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync_i,
    input  logic                wr_en,
    input  logic [3:0]          wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
`ifdef CLK_DIV_GEN_ONESHOT_EN
    input  logic [CHANNELS-1:0] oneshot_i,
    output logic [CHANNELS-1:0] done_o,
`endif
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] sq_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    free_cnt_q, free_cnt_d;
    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    div_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] sq_q,   sq_d;
`ifdef CLK_DIV_GEN_ONESHOT_EN
    logic [CHANNELS-1:0] done_q, done_d;
`endif

    // Write decode: the full 4-bit index is compared, so indices at or above
    // CHANNELS match no channel and the write is dropped.
    logic [CHANNELS-1:0] w_wr_hit;

    // Decode which channel (if any) the current write targets
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_wr_hit[i] = wr_en && (wr_ch == 4'(i));
        end
    end

    // Free-running counter: wraps naturally at 2^WIDTH
    always_comb begin
        free_cnt_d = free_cnt_q + WIDTH'(1);
    end

    // Per-channel next state, priority: write > disable > sync > terminal > count
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = '0;
        sq_d   = sq_q;
`ifdef CLK_DIV_GEN_ONESHOT_EN
        done_d = done_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr_hit[i]) begin
                // New period starts cleanly from zero; square wave phase kept
                div_d[i] = wr_div;
                cnt_d[i] = '0;
`ifdef CLK_DIV_GEN_ONESHOT_EN
                done_d[i] = 1'b0;
`endif
            end else if (!ch_en[i]) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
`ifdef CLK_DIV_GEN_ONESHOT_EN
                done_d[i] = 1'b0;
`endif
            end else if (sync_i) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
`ifdef CLK_DIV_GEN_ONESHOT_EN
                done_d[i] = 1'b0;
`endif
`ifdef CLK_DIV_GEN_ONESHOT_EN
            end else if (done_q[i]) begin
                // One-shot already fired: park at zero until cleared
                cnt_d[i] = '0;
`endif
            end else if (cnt_q[i] == div_q[i]) begin
                // Terminal compare is equality, so an all-ones divisor
                // returns to zero without overflowing past it
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                sq_d[i]   = ~sq_q[i];
`ifdef CLK_DIV_GEN_ONESHOT_EN
                done_d[i] = oneshot_i[i];
`endif
            end else begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_cnt_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= DEFAULT_DIV;
                cnt_q[i] <= '0;
            end
            tick_q <= '0;
            sq_q   <= '0;
`ifdef CLK_DIV_GEN_ONESHOT_EN
            done_q <= '0;
`endif
        end else begin
            free_cnt_q <= free_cnt_d;
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            tick_q <= tick_d;
            sq_q   <= sq_d;
`ifdef CLK_DIV_GEN_ONESHOT_EN
            done_q <= done_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------------
    assign free_cnt = free_cnt_q;
    assign tick_o   = tick_q;
    assign sq_o     = sq_q;
`ifdef CLK_DIV_GEN_ONESHOT_EN
    assign done_o   = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_gen
//  Description : Directed self-checking bench for clk_div_gen (32-bit,
//                4-channel instance plus a 4-bit instance for wrap cases).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int W4 = 4;

    logic         clk;
    logic         rst;
    logic         clk_run;

    // Main instance signals
    logic [W-1:0] free_cnt;
    logic [N-1:0] ch_en;
    logic         sync_i;
    logic         wr_en;
    logic [3:0]   wr_ch;
    logic [W-1:0] wr_div;
    logic [N-1:0] tick_o;
    logic [N-1:0] sq_o;

    // Narrow instance signals
    logic [W4-1:0] free_cnt4;
    logic [N-1:0]  ch_en4;
    logic          sync4;
    logic          wr_en4;
    logic [3:0]    wr_ch4;
    logic [W4-1:0] wr_div4;
    logic [N-1:0]  tick4;
    logic [N-1:0]  sq4;

`ifdef CLK_DIV_GEN_ONESHOT_EN
    logic [N-1:0] oneshot_i;
    logic [N-1:0] done_o;
    logic [N-1:0] oneshot4;
    logic [N-1:0] done4;
`endif

    int pass_cnt;
    int total_cnt;

    logic [N-1:0] exp_tick;
    logic [N-1:0] exp_sq;

    clk_div_gen #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .free_cnt (free_cnt),
        .ch_en    (ch_en),
        .sync_i   (sync_i),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
`ifdef CLK_DIV_GEN_ONESHOT_EN
        .oneshot_i(oneshot_i),
        .done_o   (done_o),
`endif
        .tick_o   (tick_o),
        .sq_o     (sq_o)
    );

    clk_div_gen #(.WIDTH(W4), .CHANNELS(N)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .free_cnt (free_cnt4),
        .ch_en    (ch_en4),
        .sync_i   (sync4),
        .wr_en    (wr_en4),
        .wr_ch    (wr_ch4),
        .wr_div   (wr_div4),
`ifdef CLK_DIV_GEN_ONESHOT_EN
        .oneshot_i(oneshot4),
        .done_o   (done4),
`endif
        .tick_o   (tick4),
        .sq_o     (sq4)
    );

    // Gated clock so reset can be checked with the clock stopped
    always #5 if (clk_run) clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_div(input logic [3:0] ch, input logic [W-1:0] d);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = d;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        total_cnt++;
        if (free_cnt !== '0) $display("FAIL reset_free_cnt got %h exp 0", free_cnt);
        else pass_cnt++;
        total_cnt++;
        if (tick_o !== '0) $display("FAIL reset_tick got %b exp 0000", tick_o);
        else pass_cnt++;
        total_cnt++;
        if (sq_o !== '0) $display("FAIL reset_sq got %b exp 0000", sq_o);
        else pass_cnt++;
        total_cnt++;
        if (free_cnt4 !== '0) $display("FAIL reset_free_cnt4 got %h exp 0", free_cnt4);
        else pass_cnt++;
`ifdef CLK_DIV_GEN_ONESHOT_EN
        total_cnt++;
        if (done_o !== '0 || done4 !== '0) $display("FAIL reset_done got %b/%b exp 0000", done_o, done4);
        else pass_cnt++;
`endif
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) step();
        total_cnt++;
        if (free_cnt !== 32'd10) $display("FAIL free_cnt_10 got %0d exp 10", free_cnt);
        else pass_cnt++;
        total_cnt++;
        if (free_cnt4 !== 4'd10) $display("FAIL free_cnt4_10 got %0d exp 10", free_cnt4);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        repeat (5) step();
        total_cnt++;
        if (free_cnt4 !== 4'd15) $display("FAIL wrap_pre got %0d exp 15", free_cnt4);
        else pass_cnt++;
        step();
        total_cnt++;
        if (free_cnt4 !== 4'd0) $display("FAIL wrap_post got %0d exp 0", free_cnt4);
        else pass_cnt++;
    endtask

    task automatic test_period();
        write_div(4'd1, 32'd3);
        ch_en = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_tick = (k % 4 == 0) ? 4'b0010 : 4'b0000;
            exp_sq   = (((k / 4) % 2) == 1) ? 4'b0010 : 4'b0000;
            total_cnt++;
            if (tick_o !== exp_tick) $display("FAIL period_tick k=%0d got %b exp %b", k, tick_o, exp_tick);
            else pass_cnt++;
            total_cnt++;
            if (sq_o !== exp_sq) $display("FAIL period_sq k=%0d got %b exp %b", k, sq_o, exp_sq);
            else pass_cnt++;
        end
        ch_en = 4'b0000;
        step();
    endtask

    task automatic test_d0();
        write_div(4'd0, 32'd0);
        ch_en = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_sq = (k % 2 == 1) ? 4'b0001 : 4'b0000;
            total_cnt++;
            if (tick_o !== 4'b0001) $display("FAIL d0_tick k=%0d got %b exp 0001", k, tick_o);
            else pass_cnt++;
            total_cnt++;
            if (sq_o !== exp_sq) $display("FAIL d0_sq k=%0d got %b exp %b", k, sq_o, exp_sq);
            else pass_cnt++;
        end
        ch_en = 4'b0000;
        step();
        total_cnt++;
        if (tick_o !== 4'b0000 || sq_o !== 4'b0000) $display("FAIL d0_disable got %b/%b exp 0000/0000", tick_o, sq_o);
        else pass_cnt++;
    endtask

    task automatic test_rewrite();
        write_div(4'd2, 32'd9);
        ch_en = 4'b0100;
        repeat (5) step();
        total_cnt++;
        if (tick_o !== 4'b0000) $display("FAIL rewrite_pre got %b exp 0000", tick_o);
        else pass_cnt++;
        write_div(4'd2, 32'd1);
        total_cnt++;
        if (tick_o !== 4'b0000 || sq_o !== 4'b0000) $display("FAIL rewrite_edge got %b/%b exp 0000/0000", tick_o, sq_o);
        else pass_cnt++;
        for (int k = 1; k <= 10; k++) begin
            // Out-of-range writes in the middle must not disturb channel 2
            if (k == 7) begin wr_en = 1'b1; wr_ch = 4'd6; wr_div = 32'd5; end
            if (k == 8) begin wr_ch = 4'd7; wr_div = 32'd0; end
            if (k == 9) wr_en = 1'b0;
            step();
            exp_tick = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            exp_sq   = (((k / 2) % 2) == 1) ? 4'b0100 : 4'b0000;
            total_cnt++;
            if (tick_o !== exp_tick) $display("FAIL rewrite_tick k=%0d got %b exp %b", k, tick_o, exp_tick);
            else pass_cnt++;
            total_cnt++;
            if (sq_o !== exp_sq) $display("FAIL rewrite_sq k=%0d got %b exp %b", k, sq_o, exp_sq);
            else pass_cnt++;
        end
        ch_en = 4'b0000;
        step();
    endtask

    task automatic test_sync_priority();
        write_div(4'd0, 32'd4);
        write_div(4'd1, 32'd6);
        ch_en = 4'b0011;
        repeat (8) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        total_cnt++;
        if (tick_o !== 4'b0000 || sq_o !== 4'b0000) $display("FAIL sync_clear got %b/%b exp 0000/0000", tick_o, sq_o);
        else pass_cnt++;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_tick = {2'b00, (k % 7 == 0), (k % 5 == 0)};
            exp_sq   = {2'b00, ((k / 7) % 2 == 1), ((k / 5) % 2 == 1)};
            total_cnt++;
            if (tick_o !== exp_tick) $display("FAIL sync_tick k=%0d got %b exp %b", k, tick_o, exp_tick);
            else pass_cnt++;
            total_cnt++;
            if (sq_o !== exp_sq) $display("FAIL sync_sq k=%0d got %b exp %b", k, sq_o, exp_sq);
            else pass_cnt++;
        end
        // Write to ch0 coincides with sync: ch0 takes D=2 and keeps sq, ch1 syncs
        wr_en  = 1'b1;
        wr_ch  = 4'd0;
        wr_div = 32'd2;
        sync_i = 1'b1;
        step();
        wr_en  = 1'b0;
        sync_i = 1'b0;
        total_cnt++;
        if (tick_o !== 4'b0000 || sq_o !== 4'b0001) $display("FAIL prio_edge got %b/%b exp 0000/0001", tick_o, sq_o);
        else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_tick = {3'b000, (k % 3 == 0)};
            exp_sq   = {3'b000, ((k / 3) % 2 == 0)};
            total_cnt++;
            if (tick_o !== exp_tick) $display("FAIL prio_tick k=%0d got %b exp %b", k, tick_o, exp_tick);
            else pass_cnt++;
            total_cnt++;
            if (sq_o !== exp_sq) $display("FAIL prio_sq k=%0d got %b exp %b", k, sq_o, exp_sq);
            else pass_cnt++;
        end
        ch_en = 4'b0000;
        step();
    endtask

    task automatic test_dmax();
        wr_en4  = 1'b1;
        wr_ch4  = 4'd0;
        wr_div4 = 4'hF;
        step();
        wr_en4  = 1'b0;
        ch_en4  = 4'b0001;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_tick = {3'b000, (k % 16 == 0)};
            exp_sq   = {3'b000, ((k / 16) % 2 == 1)};
            total_cnt++;
            if (tick4 !== exp_tick) $display("FAIL dmax_tick k=%0d got %b exp %b", k, tick4, exp_tick);
            else pass_cnt++;
            total_cnt++;
            if (sq4 !== exp_sq) $display("FAIL dmax_sq k=%0d got %b exp %b", k, sq4, exp_sq);
            else pass_cnt++;
        end
        ch_en4 = 4'b0000;
        step();
    endtask

`ifdef CLK_DIV_GEN_ONESHOT_EN
    task automatic test_oneshot();
        write_div(4'd3, 32'd2);
        oneshot_i = 4'b1000;
        ch_en     = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_tick = (k == 3) ? 4'b1000 : 4'b0000;
            exp_sq   = (k >= 3) ? 4'b1000 : 4'b0000;
            total_cnt++;
            if (tick_o !== exp_tick) $display("FAIL oneshot_tick k=%0d got %b exp %b", k, tick_o, exp_tick);
            else pass_cnt++;
            total_cnt++;
            if (done_o !== exp_sq) $display("FAIL oneshot_done k=%0d got %b exp %b", k, done_o, exp_sq);
            else pass_cnt++;
            total_cnt++;
            if (sq_o !== exp_sq) $display("FAIL oneshot_sq k=%0d got %b exp %b", k, sq_o, exp_sq);
            else pass_cnt++;
        end
        ch_en = 4'b0000;
        step();
        total_cnt++;
        if (done_o !== 4'b0000) $display("FAIL oneshot_clear got %b exp 0000", done_o);
        else pass_cnt++;
        oneshot_i = 4'b0000;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        clk       = 1'b0;
        clk_run   = 1'b0;
        rst       = 1'b1;
        ch_en     = '0;
        sync_i    = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_div    = '0;
        ch_en4    = '0;
        sync4     = 1'b0;
        wr_en4    = 1'b0;
        wr_ch4    = '0;
        wr_div4   = '0;
`ifdef CLK_DIV_GEN_ONESHOT_EN
        oneshot_i = '0;
        oneshot4  = '0;
`endif
        test_reset();
        test_wrap();
        test_period();
        test_d0();
        test_rewrite();
        test_sync_priority();
        test_dmax();
`ifdef CLK_DIV_GEN_ONESHOT_EN
        test_oneshot();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
